chip8_mem_ctrl: RTL

Parametrised, synchronous, single-port CHIP-8 main memory with a request/ready handshake, registered reads and an optional 16-bit big-endian opcode fetch. After every reset it runs an internal scrub sequence that clears the array, and can optionally preload the standard hex fontset. It sits between the CPU core (fetch/load/store unit) and the display/loader logic, replacing the level-sensitive byte memory.

---
 rtl/chip8_mem_pkg.sv | 33 +++
 rtl/chip8_mem_ctrl_font_rom.sv | 15 +
 rtl/chip8_mem_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/chip8_mem_pkg.sv
// chip8_mem_pkg: shared types and constants for the CHIP-8 main memory.
// Holds the controller state enum and the standard 16x5 hex fontset.
package chip8_mem_pkg;

  localparam logic [11:0] FONT_BASE  = 12'h050;
  localparam int          FONT_BYTES = 80;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD2
  } state_t;

  localparam logic [7:0] FONTSET [0:FONT_BYTES-1] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

endpackage

// File: rtl/chip8_mem_ctrl_font_rom.sv
// chip8_font_rom: combinational glyph lookup, 7-bit index to byte.
// Indices past the 80-byte fontset read as zero.
module chip8_font_rom
  import chip8_mem_pkg::*;
(
  input  logic [6:0] idx,
  output logic [7:0] data
);

  always_comb begin
    data = 8'h00;
    if (int'(idx) < FONT_BYTES) data = FONTSET[idx];
  end

endmodule

// File: rtl/chip8_mem_ctrl.sv
// chip8_mem_ctrl: single-port CHIP-8 memory, req/ready, registered reads.
// Define CHIP8_FONT_PRELOAD_EN to load the hex fontset during the scrub.
module chip8_mem_ctrl
  import chip8_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic                wide,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic                rvalid,
  output logic [2*DATA_W-1:0] rdata,
  output logic                err,
  output logic                init_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X =
    (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(DEPTH - 1);

  state_t state_q, state_d;

  logic [IDX_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  lo_q;
  logic [DATA_W-1:0] hi_q;
  logic              hi_err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_rng;
  logic              acc;
  logic [IDX_W-1:0]  a_idx;
  logic [IDX_W-1:0]  a_nxt;
  logic              mem_we;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;
  logic [DATA_W-1:0] wbyte;
  logic [DATA_W-1:0] rbyte;
  logic [DATA_W-1:0] scrub_byte;

  assign in_rng = {1'b0, addr} < DEPTH_X;
  assign a_idx  = IDX_W'(addr);
  assign a_nxt  = (a_idx == LAST) ? '0
                                  : a_idx + 1'b1;
  assign ready  = (state_q == IDLE);
  assign acc    = req && ready;

`ifdef CHIP8_FONT_PRELOAD_EN
  logic [IDX_W-1:0] font_off;
  logic [7:0]       glyph;
  logic             in_font;

  assign font_off = cnt_q - IDX_W'(FONT_BASE);
  assign in_font  =
    (cnt_q >= IDX_W'(FONT_BASE)) &&
    (cnt_q < IDX_W'(FONT_BASE + FONT_BYTES));

  chip8_font_rom u_font (
    .idx  (7'(font_off)),
    .data (glyph)
  );

  assign scrub_byte = in_font ? DATA_W'(glyph) : '0;
`else
  assign scrub_byte = '0;
`endif

  // Scrub and CPU writes share the single write port.
  always_comb begin
    mem_we = 1'b0;
    widx   = cnt_q;
    wbyte  = scrub_byte;
    if (state_q == INIT) begin
      mem_we = 1'b1;
    end else if (acc && we && in_rng) begin
      mem_we = 1'b1;
      widx   = a_idx;
      wbyte  = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[widx] <= wbyte;
  end

  assign ridx  = (state_q == RD2) ? lo_q :
                 (in_rng ? a_idx : '0);
  assign rbyte = mem[ridx];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (cnt_q == LAST) state_d = IDLE;
      IDLE:    if (acc && !we && wide) state_d = RD2;
      RD2:     state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      hi_err_q  <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state_q <= state_d;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) init_done <= 1'b1;
      end
      if (acc) begin
        if (we) begin
          err <= !in_rng;
        end else if (wide) begin
          hi_q     <= rbyte;
          hi_err_q <= !in_rng;
          lo_q     <= a_nxt;
        end else begin
          rvalid <= 1'b1;
          err    <= !in_rng;
          rdata  <= in_rng ? {{DATA_W{1'b0}}, rbyte}
                           : '0;
        end
      end
      // Second beat of a wide fetch; range judged on the first byte only.
      if (state_q == RD2) begin
        rvalid <= 1'b1;
        err    <= hi_err_q;
        rdata  <= hi_err_q ? '0 : {hi_q, rbyte};
      end
    end
  end

endmodule
